// File: rtl/reg_native_arbiter_pkg.sv
// Shared types for the register-slave arbiter: FSM state encoding, the
// read data returned on errors, and the grant index width helper.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam int ERR_RD_DATA = 0;

    // A single master still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_native_arbiter_if.sv
// Bundle of requester-side and slave-side register bus signals around the arbiter.
// Handshake: m_req_vld[i] and its command/address/data stay stable until the
// single-cycle m_ack_vld[i]; s_req_vld is a one-cycle pulse answered by one s_ack_vld.
interface reg_native_arbiter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_MST    = 2
);
    logic [NUM_MST-1:0]            m_req_vld;
    logic [NUM_MST-1:0]            m_wr_en;
    logic [NUM_MST-1:0]            m_rd_en;
    logic [NUM_MST*ADDR_WIDTH-1:0] m_addr;
    logic [NUM_MST*DATA_WIDTH-1:0] m_wr_data;
    logic [NUM_MST-1:0]            m_ack_vld;
    logic [NUM_MST-1:0]            m_err;
    logic [DATA_WIDTH-1:0]         m_rd_data;
    logic                          s_req_vld;
    logic                          s_wr_en;
    logic                          s_rd_en;
    logic [ADDR_WIDTH-1:0]         s_addr;
    logic [DATA_WIDTH-1:0]         s_wr_data;
    logic                          s_ack_vld;
    logic [DATA_WIDTH-1:0]         s_rd_data;

    // master: the requesters plus the register slave; slave: the arbiter itself
    modport master (
        output m_req_vld, m_wr_en, m_rd_en, m_addr, m_wr_data, s_ack_vld, s_rd_data,
        input  m_ack_vld, m_err, m_rd_data, s_req_vld, s_wr_en, s_rd_en, s_addr, s_wr_data
    );

    modport slave (
        input  m_req_vld, m_wr_en, m_rd_en, m_addr, m_wr_data, s_ack_vld, s_rd_data,
        output m_ack_vld, m_err, m_rd_data, s_req_vld, s_wr_en, s_rd_en, s_addr, s_wr_data
    );

endinterface

// File: rtl/reg_native_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i,
// searching modulo NUM_MST.
module reg_arb_rr_pick #(
    parameter int NUM_MST = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_MST-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               vld_o,
    output logic [IDX_W-1:0]   idx_o
);
    localparam logic [IDX_W:0] NUM_L = (IDX_W+1)'(NUM_MST);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        vld_o = 1'b0;
        idx_o = '0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_MST; k++) begin
            sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
            if (sum >= NUM_L) begin
                sum = sum - NUM_L;
            end
            cand = sum[IDX_W-1:0];
            if (!vld_o && req_i[cand]) begin
                vld_o = 1'b1;
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/reg_native_arbiter.sv
// Round-robin arbiter sharing one register slave between NUM_MST requesters,
// one access in flight, with a local timeout guaranteeing a single acknowledge.
module reg_native_arbiter
    import reg_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_MST        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rstn,
    reg_native_arbiter_if.slave  bus,
    output logic                 busy_o,
    output arb_state_e           state_o
);
    localparam int IDX_W = idx_width(NUM_MST);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e            state_q;
    logic [IDX_W-1:0]      ptr_q, gnt_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [NUM_MST-1:0]    m_ack_vld_q, m_err_q;
    logic [DATA_WIDTH-1:0] m_rd_data_q;
    logic                  s_req_vld_q, s_wr_en_q, s_rd_en_q, busy_q;
    logic [ADDR_WIDTH-1:0] s_addr_q;
    logic [DATA_WIDTH-1:0] s_wr_data_q;

    logic                  pick_vld;
    logic [IDX_W-1:0]      pick_idx, ptr_d;
    logic                  win_wr, win_rd;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;

    reg_arb_rr_pick #(.NUM_MST(NUM_MST), .IDX_W(IDX_W)) u_pick (
        .req_i (bus.m_req_vld),
        .ptr_i (ptr_q),
        .vld_o (pick_vld),
        .idx_o (pick_idx)
    );

    always_comb begin
        win_wr    = 1'b0;
        win_rd    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                win_wr    = bus.m_wr_en[i];
                win_rd    = bus.m_rd_en[i];
                win_addr  = bus.m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_wdata = bus.m_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign ptr_d = (int'(gnt_q) == NUM_MST - 1) ? '0 : gnt_q + IDX_W'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            cnt_q       <= '0;
            m_ack_vld_q <= '0;
            m_err_q     <= '0;
            m_rd_data_q <= '0;
            s_req_vld_q <= 1'b0;
            s_wr_en_q   <= 1'b0;
            s_rd_en_q   <= 1'b0;
            s_addr_q    <= '0;
            s_wr_data_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_q  <= pick_idx;
                        busy_q <= 1'b1;
                        if (win_wr ^ win_rd) begin
                            state_q     <= ISSUE;
                            cnt_q       <= '0;
                            s_req_vld_q <= 1'b1;
                            s_wr_en_q   <= win_wr;
                            s_rd_en_q   <= win_rd;
                            s_addr_q    <= win_addr;
                            s_wr_data_q <= win_wdata;
                        end else begin
                            // Illegal command: answer locally, slave stays untouched.
                            state_q               <= RESP;
                            m_ack_vld_q[pick_idx] <= 1'b1;
                            m_err_q[pick_idx]     <= 1'b1;
                            m_rd_data_q           <= DATA_WIDTH'(ERR_RD_DATA);
                        end
                    end
                end
                ISSUE, WAIT: begin
                    s_req_vld_q <= 1'b0;
                    if (bus.s_ack_vld) begin
                        state_q            <= RESP;
                        m_ack_vld_q[gnt_q] <= 1'b1;
                        m_rd_data_q        <= s_rd_en_q ? bus.s_rd_data : '0;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q            <= RESP;
                        m_ack_vld_q[gnt_q] <= 1'b1;
                        m_err_q[gnt_q]     <= 1'b1;
                        m_rd_data_q        <= DATA_WIDTH'(ERR_RD_DATA);
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    ptr_q       <= ptr_d;
                    m_ack_vld_q <= '0;
                    m_err_q     <= '0;
                    m_rd_data_q <= '0;
                    s_wr_en_q   <= 1'b0;
                    s_rd_en_q   <= 1'b0;
                    s_addr_q    <= '0;
                    s_wr_data_q <= '0;
                    busy_q      <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.m_ack_vld = m_ack_vld_q;
    assign bus.m_err     = m_err_q;
    assign bus.m_rd_data = m_rd_data_q;
    assign bus.s_req_vld = s_req_vld_q;
    assign bus.s_wr_en   = s_wr_en_q;
    assign bus.s_rd_en   = s_rd_en_q;
    assign bus.s_addr    = s_addr_q;
    assign bus.s_wr_data = s_wr_data_q;
    assign busy_o        = busy_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_reg_native_arbiter.sv
// Bench for reg_native_arbiter: directed scenarios plus random traffic, all
// checked against a transaction-timing reference model.
module tb_reg_native_arbiter;
    import reg_arb_pkg::*;

    localparam int AW = 64;
    localparam int DW = 32;
    localparam int N  = 2;
    localparam int T  = 8;
    localparam int EW = N + N + DW;

    logic       clk;
    logic       rstn;
    logic       busy;
    arb_state_e state;

    reg_native_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_MST(N)) bus ();

    reg_native_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_MST(N), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .bus     (bus),
        .busy_o  (busy),
        .state_o (state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bench-driven inputs ----------------
    logic [N-1:0]  req, wr, rd, drop;
    logic [AW-1:0] addr [N];
    logic [DW-1:0] wdat [N];
    logic          s_ack;
    logic [DW-1:0] s_rdata;

    assign bus.m_req_vld = req;
    assign bus.m_wr_en   = wr;
    assign bus.m_rd_en   = rd;
    assign bus.s_ack_vld = s_ack;
    assign bus.s_rd_data = s_rdata;
    for (genvar g = 0; g < N; g++) begin : g_pack
        assign bus.m_addr[g*AW +: AW]    = addr[g];
        assign bus.m_wr_data[g*DW +: DW] = wdat[g];
    end

    // ---------------- stimulus knobs ----------------
    logic [N-1:0]  auto_mask;
    int            auto_pct, stray_pct, slave_delay;
    logic          stray_once;
    int            ack_q[$];
    logic [DW-1:0] rd_seq[$];

    // ---------------- reference model ----------------
    int            edge_n, mphase, mptr, mgnt, mg;
    logic          m_wr, m_rd;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdat;
    logic [N-1:0]  e_ack, e_err;
    logic          e_sreq, e_busy;
    logic [DW-1:0] e_data;
    logic [EW-1:0] exp_q[$];

    // ---------------- observation logs ----------------
    int n_checks, n_fail, sreq_cnt, last_sreq_edge, last_ack_edge;
    int ack_log[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_m_ack_vld"}, 64'(bus.m_ack_vld), 64'd0);
        check({tag, "_m_err"},     64'(bus.m_err), 64'd0);
        check({tag, "_m_rd_data"}, 64'(bus.m_rd_data), 64'd0);
        check({tag, "_s_req_vld"}, 64'(bus.s_req_vld), 64'd0);
        check({tag, "_s_wr_en"},   64'(bus.s_wr_en), 64'd0);
        check({tag, "_s_rd_en"},   64'(bus.s_rd_en), 64'd0);
        check({tag, "_s_addr"},    bus.s_addr, 64'd0);
        check({tag, "_s_wr_data"}, 64'(bus.s_wr_data), 64'd0);
        check({tag, "_busy"},      64'(busy), 64'd0);
        check({tag, "_state"},     64'(state), 64'(IDLE));
    endtask

    // Timing model: grant at edge g; slave pulse seen after g; ack sampled at
    // edge k shows after k; no ack by edge g+T means an error response then.
    task automatic model_step();
        e_ack  = '0;
        e_err  = '0;
        e_sreq = 1'b0;
        e_data = '0;
        if (mphase == 0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (mptr + k) % N;
                if (mphase == 0 && req[c]) begin
                    mgnt   = c;
                    m_wr   = wr[c];
                    m_rd   = rd[c];
                    m_addr = addr[c];
                    m_wdat = wdat[c];
                    mg     = edge_n;
                    if (m_wr != m_rd) begin
                        mphase = 1;
                        e_sreq = 1'b1;
                    end else begin
                        mphase   = 2;
                        e_ack[c] = 1'b1;
                        e_err[c] = 1'b1;
                    end
                end
            end
        end else if (mphase == 1) begin
            if (s_ack) begin
                mphase      = 2;
                e_ack[mgnt] = 1'b1;
                e_data      = m_rd ? s_rdata : '0;
            end else if (edge_n - mg == T) begin
                mphase      = 2;
                e_ack[mgnt] = 1'b1;
                e_err[mgnt] = 1'b1;
            end
        end else begin
            mphase = 0;
            mptr   = (mgnt + 1) % N;
        end
        e_busy = (mphase != 0);
        if (e_ack != '0) exp_q.push_back({e_ack, e_err, e_data});
    endtask

    // ---------------- driver tasks ----------------
    task automatic new_req(input int i, input logic w, input logic r,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]  = 1'b1;
        wr[i]   = w;
        rd[i]   = r;
        addr[i] = a;
        wdat[i] = d;
    endtask

    task automatic rand_req(input int i);
        int   r;
        logic w, rr;
        r = $urandom_range(0, 9);
        if (r == 0) begin
            w  = ($urandom_range(0, 1) == 1);
            rr = w;
        end else begin
            w  = (r < 5);
            rr = !w;
        end
        new_req(i, w, rr, {$urandom, $urandom}, $urandom);
    endtask

    task automatic step();
        int   keep[$];
        int   d;
        logic hit;
        @(posedge clk);
        edge_n++;
        model_step();
        #1;
        // scoreboard
        check("m_ack_vld", 64'(bus.m_ack_vld), 64'(e_ack));
        check("m_err", 64'(bus.m_err), 64'(e_err));
        check("s_req_vld", 64'(bus.s_req_vld), 64'(e_sreq));
        check("busy", 64'(busy), 64'(e_busy));
        if (e_sreq) begin
            check("s_addr", bus.s_addr, m_addr);
            check("s_cmd", 64'({bus.s_wr_en, bus.s_rd_en}), 64'({m_wr, m_rd}));
            check("s_wr_data", 64'(bus.s_wr_data), 64'(m_wdat));
        end
        if (bus.s_req_vld) begin
            sreq_cnt++;
            last_sreq_edge = edge_n;
        end
        if (bus.m_ack_vld != '0) begin
            last_ack_edge = edge_n;
            for (int i = 0; i < N; i++) if (bus.m_ack_vld[i]) ack_log.push_back(i);
            if (exp_q.size() == 0) begin
                check("ack_unexpected", 64'd1, 64'd0);
            end else begin
                check("ack_entry", 64'({bus.m_ack_vld, bus.m_err, bus.m_rd_data}),
                      64'(exp_q.pop_front()));
            end
        end
        // masters
        for (int i = 0; i < N; i++) begin
            if (drop[i]) begin
                req[i]  = 1'b0;
                drop[i] = 1'b0;
            end else if (req[i] && bus.m_ack_vld[i]) begin
                drop[i] = 1'b1;
            end else if (!req[i] && auto_mask[i] && $urandom_range(0, 99) < auto_pct) begin
                rand_req(i);
            end
        end
        // slave
        if (bus.s_req_vld && slave_delay != -1) begin
            d = (slave_delay == -2) ? $urandom_range(0, 10) : slave_delay;
            ack_q.push_back(edge_n + 1 + d);
        end
        hit = 1'b0;
        foreach (ack_q[j]) begin
            if (ack_q[j] == edge_n + 1) hit = 1'b1;
            else keep.push_back(ack_q[j]);
        end
        ack_q = keep;
        if (stray_pct > 0 && $urandom_range(0, 99) < stray_pct) hit = 1'b1;
        if (stray_once) begin
            hit        = 1'b1;
            stray_once = 1'b0;
        end
        s_ack   = hit;
        s_rdata = (hit && rd_seq.size() > 0) ? rd_seq.pop_front() : $urandom;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int hold);
        rstn = 1'b0;
        #1;
        reset_checks("rst_async");
        mphase = 0;
        mptr   = 0;
        exp_q.delete();
        ack_q.delete();
        s_ack = 1'b0;
        drop  = '0;
        repeat (hold) @(posedge clk);
        #1;
        reset_checks("rst_hold");
        rstn = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks = 0; n_fail = 0; sreq_cnt = 0; edge_n = 0;
        last_sreq_edge = 0; last_ack_edge = 0;
        mphase = 0; mptr = 0; mgnt = 0; mg = 0;
        m_wr = 1'b0; m_rd = 1'b0; m_addr = '0; m_wdat = '0;
        req = '0; wr = '0; rd = '0; drop = '0;
        for (int i = 0; i < N; i++) begin
            addr[i] = '0;
            wdat[i] = '0;
        end
        s_ack = 1'b0; s_rdata = '0;
        auto_mask = '0; auto_pct = 0; stray_pct = 0; stray_once = 1'b0; slave_delay = 2;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");
        rstn = 1'b1;

        // single write from master 0
        sreq_cnt = 0;
        new_req(0, 1'b1, 1'b0, 64'h10, 32'hA5A5_0001);
        run(12);
        check("t1_sreq_count", 64'(sreq_cnt), 64'd1);

        // both masters read from reset: master 0 first
        do_reset(2);
        slave_delay = 1;
        rd_seq = '{32'h11, 32'h22};
        ack_log.delete();
        new_req(0, 1'b0, 1'b1, 64'h20, '0);
        new_req(1, 1'b0, 1'b1, 64'h24, '0);
        run(16);
        check("t2_acks", 64'(ack_log.size()), 64'd2);
        if (ack_log.size() == 2) begin
            check("t2_first", 64'(ack_log[0]), 64'd0);
            check("t2_second", 64'(ack_log[1]), 64'd1);
        end

        // master 1 streams, master 0 requests once
        ack_log.delete();
        auto_mask = 2'b10; auto_pct = 100;
        new_req(0, 1'b1, 1'b0, 64'h30, 32'h3);
        run(30);
        auto_mask = '0;
        run(12);
        begin
            int pos;
            pos = -1;
            foreach (ack_log[j]) if (ack_log[j] == 0 && pos < 0) pos = j;
            check("t3_m0_served", 64'(pos >= 0 && pos <= 1), 64'd1);
        end

        // silent slave: timeout, then a stray ack in IDLE
        slave_delay = -1;
        ack_log.delete();
        new_req(0, 1'b0, 1'b1, 64'h40, '0);
        run(14);
        check("t4_timeout_lat", 64'(last_ack_edge - last_sreq_edge), 64'(T));
        stray_once = 1'b1;
        run(4);
        check("t4_acks", 64'(ack_log.size()), 64'd1);

        // illegal command never touches the slave
        sreq_cnt = 0;
        new_req(1, 1'b1, 1'b1, 64'h50, '0);
        run(6);
        check("t5_sreq_count", 64'(sreq_cnt), 64'd0);

        // reset while in WAIT; master 0 is re-granted first afterwards
        new_req(1, 1'b0, 1'b1, 64'h60, '0);
        run(1);
        new_req(0, 1'b0, 1'b1, 64'h64, '0);
        run(3);
        check("t6_in_wait", 64'(state), 64'(WAIT));
        do_reset(2);
        slave_delay = 1;
        ack_log.delete();
        run(16);
        check("t6_acks", 64'(ack_log.size()), 64'd2);
        if (ack_log.size() == 2) check("t6_first", 64'(ack_log[0]), 64'd0);

        // random traffic with random slave latency and stray acks
        auto_mask = '1; auto_pct = 30; slave_delay = -2; stray_pct = 3;
        run(3000);
        auto_mask = '0; stray_pct = 0;
        run(40);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
